// File: rtl/mem_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_fifo_ctrl_pkg : shared sizing and request decode for the FIFO | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_fifo_ctrl_pkg;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_POP      = 3'd1,
    OP_POP_REJ  = 3'd2,
    OP_PUSH     = 3'd3,
    OP_PUSH_REJ = 3'd4
  } op_e;

  // A pop request always wins; a concurrent push is simply dropped.
  function automatic op_e decode_op(input logic ren, input logic wen,
                                    input logic empty, input logic full);
    if (ren)      return empty ? OP_POP_REJ : OP_POP;
    else if (wen) return full ? OP_PUSH_REJ : OP_PUSH;
    else          return OP_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_fifo_ctrl_mem.sv
// ---------------------------------------------------------------------------
// mem_fifo_ctrl_mem : synchronous single-port storage, 1-cycle read | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_fifo_ctrl_mem #(
  parameter int DW = mem_fifo_ctrl_pkg::DW,
  parameter int AW = mem_fifo_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          ren,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [2**AW];

  // Storage is deliberately left unreset; read data returns 0 on idle cycles.
  always_ff @(posedge clk) begin
    if (wen) mem_q[addr] <= din;
    dout <= ren ? mem_q[addr] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/mem_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// mem_fifo_ctrl : read-priority FIFO controller around one memory   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_fifo_ctrl #(
  parameter int DW = mem_fifo_ctrl_pkg::DW,
  parameter int AW = mem_fifo_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ren,
  input  logic          wen,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          error,
  output logic          full,
  output logic          empty
);

  import mem_fifo_ctrl_pkg::*;

  localparam int CNT_W     = AW + 1;
  localparam int MEM_DEPTH = 2 ** AW;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rd_valid;

  op_e              op;
  logic             mem_ren;
  logic             mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_dout;

  assign full  = (count == CNT_W'(MEM_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    op       = decode_op(ren, wen, empty, full);
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = rd_ptr;
    case (op)
      OP_POP: begin
        mem_ren  = 1'b1;
        mem_addr = rd_ptr;
      end
      OP_PUSH: begin
        mem_wen  = 1'b1;
        mem_addr = wr_ptr;
      end
      default: ;
    endcase
  end

  // Pointers wrap naturally at AW bits; count carries the extra bit for full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      error    <= 1'b0;
    end else begin
      rd_valid <= (op == OP_POP);
      error    <= (op == OP_POP_REJ) || (op == OP_PUSH_REJ);
      if (op == OP_POP) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (op == OP_PUSH) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
    end
  end

  mem_fifo_ctrl_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk  (clk),
    .ren  (mem_ren),
    .wen  (mem_wen),
    .addr (mem_addr),
    .din  (din),
    .dout (mem_dout)
  );

  // Gating on rd_valid also hides a read that reset interrupted.
  assign dout = rd_valid ? mem_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_fifo_ctrl : scoreboard bench with a queue-based FIFO model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ren;
  logic       wen;
  logic [7:0] din;
  logic [7:0] dout;
  logic       error;
  logic       full;
  logic       empty;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic [7:0] mdl [$];
  exp_t       expq [$];
  int         total = 0;
  int         bad   = 0;

  mem_fifo_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .ren   (ren),
    .wen   (wen),
    .din   (din),
    .dout  (dout),
    .error (error),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One request per clock: flags checked against the model, result queued.
  task automatic cyc(input logic r, input logic w, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    chk("empty", 32'(empty), 32'(mdl.size() == 0));
    chk("full",  32'(full),  32'(mdl.size() == 128));
    ren = r;
    wen = w;
    din = d;
    x.d = 8'h00;
    x.e = 1'b0;
    if (r) begin
      if (mdl.size() == 0) x.e = 1'b1;
      else x.d = mdl.pop_front();
    end else if (w) begin
      if (mdl.size() == 128) x.e = 1'b1;
      else mdl.push_back(d);
    end
    expq.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("dout",  32'(dout),  32'(x.d));
        chk("error", 32'(error), 32'(x.e));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int pr;
    int pw;
    rst = 1'b1;
    ren = 1'b0;
    wen = 1'b0;
    din = 8'h00;
    #3;
    chk("rst_dout",  32'(dout),  32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full",  32'(full),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Pop on empty, simple two-entry flow.
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 8'h3C);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Fill, overflow, drain.
    for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 8'(i));
    cyc(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Read priority drops the concurrent push.
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Pointer wrap.
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 8'(i + 7));
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++)  cyc(1'b0, 1'b1, 8'(200 - i));
    for (int i = 0; i < 60; i++)  cyc(1'b1, 1'b0, 8'h00);

    // Random phases: push-heavy, mixed, pop-heavy, mixed.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pr = 15; pw = 90; end
        2:       begin pr = 85; pw = 30; end
        default: begin pr = 45; pw = 60; end
      endcase
      for (int i = 0; i < 300; i++)
        cyc(($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pw), 8'($urandom));
    end

    // Asynchronous reset while popped data is on dout.
    cyc(1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 8'h6B);
    cyc(1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout",  32'(dout),  32'h0);
    chk("arst_error", 32'(error), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_full",  32'(full),  32'h0);
    mdl.delete();
    #1 rst = 1'b0;
    cyc(1'b0, 1'b1, 8'hC3);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #2;
    chk("drain", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
